i2c_slave: RTL and testbench
============================

I2C_SLAVE -- requirements
Module: i2c_slave

Interface
REQ-001 Parameter Address, 7'h50, 7-bit I2C address the block SHALL respond to.
REQ-002 Parameter MinClocksPerSclHalf, 10, minimum clock cycles per SCL high/low phase; the block SHALL work correctly only when this minimum is met.
REQ-003 clock  in  1  system clock; every flop SHALL be on the rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 scl  in  1  I2C clock from the master; no clock stretching.
REQ-006 sda  inout  1  open-drain data; the block SHALL drive only 1'b0 or 1'bz.
REQ-007 rxData  out  8  last received write byte.
REQ-008 rxValid  out  1  one-cycle pulse when rxData is updated.
REQ-009 txData  in  8  read byte supplied by the user, sampled per REQ-021.
REQ-010 txRequest  out  1  one-cycle pulse requesting the next read byte.
REQ-011 busy  out  1  high while this slave is addressed.

Function
REQ-012 scl and sda SHALL each pass a 2-flop synchronizer; all detection SHALL use synchronized values and their previous-cycle copies.
REQ-013 START: synchronized sda falls while synchronized scl is high; STOP: sda rises while scl is high.
REQ-014 Rise/fall of SCL SHALL be detected from synchronized scl; data SHALL be sampled on SCL rise and the sda driver SHALL change only in the cycle after an SCL fall.
REQ-015 States: Idle, Address, AddrAck, Write, WriteAck, Read, ReadAck, Ignore.
REQ-016 START in any state SHALL enter Address with bitCount=0 and sda released; STOP in any state SHALL enter Idle, release sda, and clear busy.
REQ-017 Address: shift 8 bits MSB first on SCL rise; on 8th bit, if bits[7:1]==Address, go to AddrAck, else go to Ignore (sda never driven).
REQ-018 AddrAck: drive sda=0 from the next SCL fall until the following SCL fall; busy SHALL rise on entering AddrAck; on release, R/W=0 -> Write, R/W=1 -> Read.
REQ-019 Write: on 8th SCL rise, rxData SHALL update and rxValid pulse in the same cycle; go to WriteAck, ACK as in REQ-018, then return to Write.
REQ-020 txRequest SHALL pulse on the SCL rise of the address ACK bit when R/W=1, and on each ReadAck SCL rise where the master ACKs (sda=0).
REQ-021 txData SHALL be latched into the shift register exactly 2 cycles after txRequest; bit 7 SHALL drive at the next SCL fall.
REQ-022 Read: each SCL fall SHALL present the next bit (0 -> drive 0, 1 -> release); after the 8th bit's SCL fall, sda SHALL be released and the state SHALL enter ReadAck.
REQ-023 ReadAck: sample sda on SCL rise; 0 -> Read; 1 (NACK) -> Ignore, busy cleared.
REQ-024 Ignore: sda released; only START or STOP SHALL leave it.
REQ-025 Bit counter SHALL be 4 bits and count 0..8; it SHALL reset to 0 at START and on each byte boundary.
REQ-026 START/STOP mid-byte SHALL discard partial bytes, with no rxValid.

Reset
REQ-027 During reset, state SHALL go to Idle, sda SHALL be 1'bz, and rxData=8'h00, rxValid=0, txRequest=0, busy=0, with shift register, counter and synchronizers cleared (synchronizers to 1).
REQ-028 Reset asserted mid-transaction SHALL release sda in the cycle following the reset edge; bus activity SHALL be ignored until the next START.

Verification
REQ-029 START, 0xA0, 0x3C, STOP -> ACK on both 9th bits, rxData=0x3C with a single rxValid, busy 1 -> 0 after STOP.
REQ-030 START, 0xA2, 0x55, STOP -> sda never driven, no rxValid or txRequest, busy stays 0.
REQ-031 START, 0xA1, txData=0x96, master NACK -> sda bits 1,0,0,1,0,1,1,0, one txRequest, sda released, busy 0.
REQ-032 START, 0xA0, 0x01, repeated START, 0xA1, reads 0x5A (ACK) then 0xC3 (NACK), STOP -> rxData=0x01, two txRequest pulses, correct bits on sda.
REQ-033 Reset during bit 3 of a read -> sda=1'bz next cycle, all outputs 0; the subsequent write 0xA0, 0x7E -> rxData=0x7E.
REQ-034 STOP after 4 bits of a write byte -> Idle, no rxValid, busy 0.

Source files
------------

// File: rtl/i2c_slave.sv
// i2c_slave: 7-bit addressed I2C target handling byte writes and reads with ACK/NACK.
// sda is open-drain: the block only ever pulls the line low or releases it.
module i2c_slave #(
  parameter logic [6:0] Address             = 7'h50,
  parameter int         MinClocksPerSclHalf = 10
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       scl,
  inout  wire        sda,
  output logic [7:0] rxData,
  output logic       rxValid,
  input  logic [7:0] txData,
  output logic       txRequest,
  output logic       busy,
  output logic [2:0] debug_state
);

  // Two synchronizer flops plus the edge-detect copy must fit inside one SCL phase.
  if (MinClocksPerSclHalf < 4) begin : g_half_check
    $error("i2c_slave: MinClocksPerSclHalf too small for synchronized edge detection");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_ADDRESS, S_ADDR_ACK, S_WRITE, S_WRITE_ACK, S_READ, S_READ_ACK, S_IGNORE
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] bit_count_q, bit_count_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rw_q, rw_d;
  logic       ack_q, ack_d;
  logic       sda_oe_q, sda_oe_d;
  logic       rx_valid_q, rx_valid_d;
  logic       tx_request_q, tx_request_d;
  logic       busy_q, busy_d;
  logic       tx_pend_q;

  logic scl_s1, scl_s2, scl_prev;
  logic sda_s1, sda_s2, sda_prev;

  assign sda = sda_oe_q ? 1'b0 : 1'bz;

  // rxValid and txRequest are single-cycle strobes with no back-pressure: rxData is
  // valid in the rxValid cycle, and txData must be stable in the cycle after txRequest.
  assign rxData      = rx_data_q;
  assign rxValid     = rx_valid_q;
  assign txRequest   = tx_request_q;
  assign busy        = busy_q;
  assign debug_state = state_q;

  logic scl_rise, scl_fall, start_det, stop_det;
  assign scl_rise  = scl_s2 & ~scl_prev;
  assign scl_fall  = ~scl_s2 & scl_prev;
  assign start_det = scl_s2 & scl_prev & sda_prev & ~sda_s2;
  assign stop_det  = scl_s2 & scl_prev & ~sda_prev & sda_s2;

  always_ff @(posedge clock) begin
    if (reset) begin
      scl_s1       <= 1'b1;
      scl_s2       <= 1'b1;
      scl_prev     <= 1'b1;
      sda_s1       <= 1'b1;
      sda_s2       <= 1'b1;
      sda_prev     <= 1'b1;
      state_q      <= S_IDLE;
      bit_count_q  <= 4'd0;
      shift_q      <= 8'h00;
      rx_data_q    <= 8'h00;
      rw_q         <= 1'b0;
      ack_q        <= 1'b0;
      sda_oe_q     <= 1'b0;
      rx_valid_q   <= 1'b0;
      tx_request_q <= 1'b0;
      busy_q       <= 1'b0;
      tx_pend_q    <= 1'b0;
    end else begin
      scl_s1       <= scl;
      scl_s2       <= scl_s1;
      scl_prev     <= scl_s2;
      sda_s1       <= sda;
      sda_s2       <= sda_s1;
      sda_prev     <= sda_s2;
      state_q      <= state_d;
      bit_count_q  <= bit_count_d;
      shift_q      <= shift_d;
      rx_data_q    <= rx_data_d;
      rw_q         <= rw_d;
      ack_q        <= ack_d;
      sda_oe_q     <= sda_oe_d;
      rx_valid_q   <= rx_valid_d;
      tx_request_q <= tx_request_d;
      busy_q       <= busy_d;
      tx_pend_q    <= tx_request_q;
    end
  end

  always_comb begin
    state_d      = state_q;
    bit_count_d  = bit_count_q;
    shift_d      = shift_q;
    rx_data_d    = rx_data_q;
    rw_d         = rw_q;
    ack_d        = ack_q;
    sda_oe_d     = sda_oe_q;
    rx_valid_d   = 1'b0;
    tx_request_d = 1'b0;
    busy_d       = busy_q;

    // Read byte is captured two cycles after the request strobe.
    if (tx_pend_q) shift_d = txData;

    if (start_det) begin
      state_d     = S_ADDRESS;
      bit_count_d = 4'd0;
      sda_oe_d    = 1'b0;
      ack_d       = 1'b0;
      busy_d      = 1'b0;
    end else if (stop_det) begin
      state_d     = S_IDLE;
      bit_count_d = 4'd0;
      sda_oe_d    = 1'b0;
      ack_d       = 1'b0;
      busy_d      = 1'b0;
    end else begin
      case (state_q)
        S_ADDRESS: begin
          if (scl_rise) begin
            shift_d = {shift_q[6:0], sda_s2};
            if (bit_count_q == 4'd7) begin
              bit_count_d = 4'd0;
              rw_d        = sda_s2;
              if (shift_q[6:0] == Address) begin
                state_d = S_ADDR_ACK;
                busy_d  = 1'b1;
              end else begin
                state_d = S_IGNORE;
              end
            end else begin
              bit_count_d = bit_count_q + 4'd1;
            end
          end
        end
        S_ADDR_ACK: begin
          if (scl_fall) begin
            if (!ack_q) begin
              sda_oe_d = 1'b1;
              ack_d    = 1'b1;
            end else begin
              ack_d       = 1'b0;
              bit_count_d = 4'd0;
              if (rw_q) begin
                state_d  = S_READ;
                sda_oe_d = ~shift_q[7];
                shift_d  = {shift_q[6:0], 1'b0};
              end else begin
                state_d  = S_WRITE;
                sda_oe_d = 1'b0;
              end
            end
          end else if (scl_rise && ack_q && rw_q) begin
            tx_request_d = 1'b1;
          end
        end
        S_WRITE: begin
          if (scl_rise) begin
            shift_d = {shift_q[6:0], sda_s2};
            if (bit_count_q == 4'd7) begin
              bit_count_d = 4'd0;
              rx_data_d   = {shift_q[6:0], sda_s2};
              rx_valid_d  = 1'b1;
              state_d     = S_WRITE_ACK;
            end else begin
              bit_count_d = bit_count_q + 4'd1;
            end
          end
        end
        S_WRITE_ACK: begin
          if (scl_fall) begin
            if (!ack_q) begin
              sda_oe_d = 1'b1;
              ack_d    = 1'b1;
            end else begin
              sda_oe_d    = 1'b0;
              ack_d       = 1'b0;
              bit_count_d = 4'd0;
              state_d     = S_WRITE;
            end
          end
        end
        S_READ: begin
          // bit_count tracks bits already clocked out by the master.
          if (scl_rise && bit_count_q != 4'd8) begin
            bit_count_d = bit_count_q + 4'd1;
          end else if (scl_fall) begin
            if (bit_count_q == 4'd8) begin
              sda_oe_d    = 1'b0;
              bit_count_d = 4'd0;
              state_d     = S_READ_ACK;
            end else begin
              sda_oe_d = ~shift_q[7];
              shift_d  = {shift_q[6:0], 1'b0};
            end
          end
        end
        S_READ_ACK: begin
          if (scl_rise) begin
            if (!sda_s2) begin
              tx_request_d = 1'b1;
              ack_d        = 1'b1;
            end else begin
              state_d = S_IGNORE;
              busy_d  = 1'b0;
            end
          end else if (scl_fall && ack_q) begin
            ack_d       = 1'b0;
            bit_count_d = 4'd0;
            state_d     = S_READ;
            sda_oe_d    = ~shift_q[7];
            shift_d     = {shift_q[6:0], 1'b0};
          end
        end
        S_IGNORE: sda_oe_d = 1'b0;
        default:  sda_oe_d = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_slave.sv
// Directed bench for i2c_slave: a bit-banged master drives scl/sda, monitors count strobes.
module tb_i2c_slave;
  localparam int HALF = 20;
  localparam int QTR  = 10;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       scl = 1'b1;
  logic       m_sda_low = 1'b0;
  logic [7:0] txData = 8'h00;
  wire        sda;
  logic [7:0] rxData;
  logic       rxValid, txRequest, busy;
  logic [2:0] debug_state;

  int checks = 0;
  int errors = 0;
  int rx_cnt = 0, tx_cnt = 0, drv_cnt = 0, busy_cnt = 0;

  logic [7:0] tx_q[$];
  logic [7:0] tx_cur = 8'h00;
  logic       tx_s1 = 1'b0, tx_s2 = 1'b0;

  assign sda = m_sda_low ? 1'b0 : 1'bz;
  pullup (sda);

  always #5 clock = ~clock;

  i2c_slave dut (
    .clock(clock), .reset(reset), .scl(scl), .sda(sda),
    .rxData(rxData), .rxValid(rxValid), .txData(txData),
    .txRequest(txRequest), .busy(busy), .debug_state(debug_state)
  );

  // Monitors sample mid-cycle; txData answers a request in the following cycle only.
  always @(negedge clock) begin
    if (rxValid === 1'b1) rx_cnt++;
    if (busy === 1'b1) busy_cnt++;
    if (sda === 1'b0 && !m_sda_low) drv_cnt++;
    if (tx_s2) begin
      txData = ~tx_cur;
      tx_s2 = 1'b0;
    end
    if (tx_s1) begin
      if (tx_q.size() > 0) tx_cur = tx_q.pop_front();
      else tx_cur = 8'hFF;
      txData = tx_cur;
      tx_s1 = 1'b0;
      tx_s2 = 1'b1;
    end
    if (txRequest === 1'b1) begin
      tx_cnt++;
      tx_s1 = 1'b1;
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic i2c_start();
    wait_clk(QTR); m_sda_low = 1'b0;
    wait_clk(QTR); scl = 1'b1;
    wait_clk(HALF); m_sda_low = 1'b1;
    wait_clk(HALF); scl = 1'b0;
  endtask

  task automatic i2c_stop();
    wait_clk(QTR); m_sda_low = 1'b1;
    wait_clk(QTR); scl = 1'b1;
    wait_clk(HALF); m_sda_low = 1'b0;
    wait_clk(HALF);
  endtask

  task automatic write_bit(input logic b);
    wait_clk(QTR); m_sda_low = ~b;
    wait_clk(QTR); scl = 1'b1;
    wait_clk(HALF); scl = 1'b0;
  endtask

  task automatic read_bit(output logic b);
    wait_clk(2); m_sda_low = 1'b0;
    wait_clk(HALF - 2); scl = 1'b1;
    wait_clk(QTR); b = (sda === 1'b0) ? 1'b0 : 1'b1;
    wait_clk(QTR); scl = 1'b0;
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(ack);
  endtask

  task automatic read_byte(output logic [7:0] d, input logic nack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      d[i] = b;
    end
    write_bit(nack);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    wait_clk(5);
    checks++; if (rxData !== 8'h00) begin errors++; $display("FAIL reset_rxdata: got %h want 00", rxData); end
    checks++; if (rxValid !== 1'b0) begin errors++; $display("FAIL reset_rxvalid: got %b want 0", rxValid); end
    checks++; if (txRequest !== 1'b0) begin errors++; $display("FAIL reset_txrequest: got %b want 0", txRequest); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (sda !== 1'b1) begin errors++; $display("FAIL reset_sda: got %b want 1 (released)", sda); end
    checks++; if (debug_state !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", debug_state); end
    reset = 1'b0;
    wait_clk(5);
  endtask

  task automatic test_write();
    logic ack;
    rx_cnt = 0;
    i2c_start();
    write_byte(8'hA0, ack);
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL write_addr_ack: got %b want 0", ack); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL write_busy: got %b want 1", busy); end
    write_byte(8'h3C, ack);
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL write_data_ack: got %b want 0", ack); end
    i2c_stop();
    checks++; if (rxData !== 8'h3C) begin errors++; $display("FAIL write_rxdata: got %h want 3c", rxData); end
    checks++; if (rx_cnt !== 1) begin errors++; $display("FAIL write_rxvalid_count: got %0d want 1", rx_cnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL write_busy_after_stop: got %b want 0", busy); end
  endtask

  task automatic test_other_address();
    logic ack;
    rx_cnt = 0; tx_cnt = 0; drv_cnt = 0; busy_cnt = 0;
    i2c_start();
    write_byte(8'hA2, ack);
    checks++; if (ack !== 1'b1) begin errors++; $display("FAIL other_addr_nack: got %b want 1", ack); end
    write_byte(8'h55, ack);
    checks++; if (ack !== 1'b1) begin errors++; $display("FAIL other_data_nack: got %b want 1", ack); end
    i2c_stop();
    checks++; if (drv_cnt !== 0) begin errors++; $display("FAIL other_sda_driven: got %0d cycles want 0", drv_cnt); end
    checks++; if (rx_cnt !== 0) begin errors++; $display("FAIL other_rxvalid: got %0d want 0", rx_cnt); end
    checks++; if (tx_cnt !== 0) begin errors++; $display("FAIL other_txrequest: got %0d want 0", tx_cnt); end
    checks++; if (busy_cnt !== 0) begin errors++; $display("FAIL other_busy: got %0d cycles want 0", busy_cnt); end
  endtask

  task automatic test_read_nack();
    logic ack;
    logic [7:0] d;
    tx_cnt = 0;
    tx_q.push_back(8'h96);
    i2c_start();
    write_byte(8'hA1, ack);
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL read_addr_ack: got %b want 0", ack); end
    read_byte(d, 1'b1);
    checks++; if (d !== 8'h96) begin errors++; $display("FAIL read_bits: got %h want 96", d); end
    checks++; if (tx_cnt !== 1) begin errors++; $display("FAIL read_txrequest_count: got %0d want 1", tx_cnt); end
    wait_clk(QTR);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL read_busy_after_nack: got %b want 0", busy); end
    checks++; if (sda !== 1'b1) begin errors++; $display("FAIL read_sda_released: got %b want 1", sda); end
    checks++; if (debug_state !== 3'd7) begin errors++; $display("FAIL read_state_ignore: got %0d want 7", debug_state); end
    i2c_stop();
  endtask

  task automatic test_back_to_back();
    logic ack;
    logic [7:0] d;
    rx_cnt = 0; tx_cnt = 0;
    tx_q.push_back(8'h5A);
    tx_q.push_back(8'hC3);
    i2c_start();
    write_byte(8'hA0, ack);
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL b2b_waddr_ack: got %b want 0", ack); end
    write_byte(8'h01, ack);
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL b2b_wdata_ack: got %b want 0", ack); end
    i2c_start();
    write_byte(8'hA1, ack);
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL b2b_raddr_ack: got %b want 0", ack); end
    read_byte(d, 1'b0);
    checks++; if (d !== 8'h5A) begin errors++; $display("FAIL b2b_read0: got %h want 5a", d); end
    read_byte(d, 1'b1);
    checks++; if (d !== 8'hC3) begin errors++; $display("FAIL b2b_read1: got %h want c3", d); end
    i2c_stop();
    checks++; if (rxData !== 8'h01) begin errors++; $display("FAIL b2b_rxdata: got %h want 01", rxData); end
    checks++; if (rx_cnt !== 1) begin errors++; $display("FAIL b2b_rxvalid_count: got %0d want 1", rx_cnt); end
    checks++; if (tx_cnt !== 2) begin errors++; $display("FAIL b2b_txrequest_count: got %0d want 2", tx_cnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_busy: got %b want 0", busy); end
  endtask

  task automatic test_reset_mid_read();
    logic ack, b;
    tx_q.push_back(8'h12);
    i2c_start();
    write_byte(8'hA1, ack);
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL rst_addr_ack: got %b want 0", ack); end
    read_bit(b);
    read_bit(b);
    wait_clk(QTR);
    checks++; if (sda !== 1'b0) begin errors++; $display("FAIL rst_bit3_driven: got %b want 0", sda); end
    reset = 1'b1;
    wait_clk(1);
    checks++; if (sda !== 1'b1) begin errors++; $display("FAIL rst_sda_released: got %b want 1", sda); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
    checks++; if (rxData !== 8'h00) begin errors++; $display("FAIL rst_rxdata: got %h want 00", rxData); end
    checks++; if ({rxValid, txRequest} !== 2'b00) begin errors++; $display("FAIL rst_strobes: got %b want 00", {rxValid, txRequest}); end
    checks++; if (debug_state !== 3'd0) begin errors++; $display("FAIL rst_state: got %0d want 0", debug_state); end
    reset = 1'b0;
    drv_cnt = 0; tx_cnt = 0; rx_cnt = 0;
    wait_clk(QTR - 1); scl = 1'b1;
    wait_clk(HALF); scl = 1'b0;
    for (int i = 0; i < 6; i++) read_bit(b);
    checks++; if (drv_cnt !== 0) begin errors++; $display("FAIL rst_ignore_sda: got %0d cycles want 0", drv_cnt); end
    checks++; if (tx_cnt !== 0) begin errors++; $display("FAIL rst_ignore_txrequest: got %0d want 0", tx_cnt); end
    i2c_stop();
    i2c_start();
    write_byte(8'hA0, ack);
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL rst_waddr_ack: got %b want 0", ack); end
    write_byte(8'h7E, ack);
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL rst_wdata_ack: got %b want 0", ack); end
    i2c_stop();
    checks++; if (rxData !== 8'h7E) begin errors++; $display("FAIL rst_rxdata_after: got %h want 7e", rxData); end
    checks++; if (rx_cnt !== 1) begin errors++; $display("FAIL rst_rxvalid_count: got %0d want 1", rx_cnt); end
  endtask

  task automatic test_stop_mid_byte();
    logic ack;
    rx_cnt = 0;
    i2c_start();
    write_byte(8'hA0, ack);
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL partial_addr_ack: got %b want 0", ack); end
    write_bit(1'b1);
    write_bit(1'b0);
    write_bit(1'b1);
    write_bit(1'b1);
    i2c_stop();
    checks++; if (rx_cnt !== 0) begin errors++; $display("FAIL partial_rxvalid: got %0d want 0", rx_cnt); end
    checks++; if (rxData !== 8'h7E) begin errors++; $display("FAIL partial_rxdata: got %h want 7e", rxData); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL partial_busy: got %b want 0", busy); end
    checks++; if (debug_state !== 3'd0) begin errors++; $display("FAIL partial_state: got %0d want 0", debug_state); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_other_address();
    test_read_nack();
    test_back_to_back();
    test_reset_mid_read();
    test_stop_mid_byte();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
